memref_port_responder: RTL and testbench

- Memory-side responder for one generated memref port (the `*_p0_*` addr/rd/wr signal group); it is the other end of the port that the kernel drives as initiator.
- Replaces the separate rd/wr memory models in kernel benches with one single-port RAM that has a fixed read latency.
- Adds a bench-side preload port, access counters and sticky protocol-error flags, so testbenches can check access discipline as well as data.

---
 rtl/memref_port_responder.sv | 126 ++++++++++++
 tb/tb_memref_port_responder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memref_port_responder.sv
// Memory-side responder for one memref port: single-port RAM with a fixed
// read latency, a bench preload port, saturating access counters and sticky
// protocol-error flags.
module memref_port_responder #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SIZE          = 64,
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned CHECK_ADDR_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_en,
    input  logic [ADDR_W-1:0] addr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [WIDTH-1:0]  init_data,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              err_conflict,
    output logic              err_range,
    output logic              err_proto
);

    // One extra bit so SIZE == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] SizeLim = (ADDR_W + 1)'(SIZE);

    logic             addr_ok;
    logic             init_ok;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] mem [SIZE];

    logic [RD_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]      dat_q [RD_LATENCY];

    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;
    logic        err_conflict_q;
    logic        err_range_q;
    logic        err_proto_q;

    assign addr_ok = {1'b0, addr_data} < SizeLim;
    assign init_ok = {1'b0, init_addr} < SizeLim;

    // Read-before-write word; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            rd_word = mem[addr_data];
        end
    end

    // Memory array: deliberately not reset; port write beats preload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (addr_ok) begin
                mem[addr_data] <= wr_data;
            end
        end else if (init_en && init_ok) begin
            mem[init_addr] <= init_data;
        end
    end

    // Read shift pipeline; data stages only load on valid so the last word holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    // Saturating access counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q     <= '0;
            wr_count_q     <= '0;
            err_conflict_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            if (rd_en && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (wr_en && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if ((rd_en || init_en) && wr_en) begin
                err_conflict_q <= 1'b1;
            end
            if (((rd_en || wr_en) && !addr_ok) || (init_en && !init_ok)) begin
                err_range_q <= 1'b1;
            end
            if ((CHECK_ADDR_EN != 0) && (rd_en || wr_en) && !addr_en) begin
                err_proto_q <= 1'b1;
            end
        end
    end

    assign rd_valid     = vld_q[RD_LATENCY-1];
    assign rd_data      = dat_q[RD_LATENCY-1];
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign err_conflict = err_conflict_q;
    assign err_range    = err_range_q;
    assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_memref_port_responder.sv
// Scoreboard bench for memref_port_responder. Two instances share stimulus:
// A (SIZE=48, RD_LATENCY=3, CHECK_ADDR_EN=1) and B (defaults: 64, 1, 0).
module tb_memref_port_responder;

    localparam int SZ_A = 48;
    localparam int LAT_A = 3;
    localparam int SZ_B = 64;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        addr_en = 1'b0;
    logic [5:0]  addr_data = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        init_en = 1'b0;
    logic [5:0]  init_addr = '0;
    logic [31:0] init_data = '0;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [15:0] rd_count_a, rd_count_b, wr_count_a, wr_count_b;
    logic        err_conflict_a, err_conflict_b, err_range_a, err_range_b;
    logic        err_proto_a, err_proto_b;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    // Bench model state, index 0 = instance A, 1 = instance B.
    logic [31:0] mem_m [2][64];
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
    logic        econf [2];
    logic        erng [2];
    logic        eprot [2];
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    wire [34:0] st_a = {rd_count_a, wr_count_a, err_conflict_a, err_range_a, err_proto_a};
    wire [34:0] st_b = {rd_count_b, wr_count_b, err_conflict_b, err_range_b, err_proto_b};

    memref_port_responder #(
        .WIDTH(32), .SIZE(SZ_A), .ADDR_W(6), .RD_LATENCY(LAT_A), .CHECK_ADDR_EN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .addr_en(addr_en), .addr_data(addr_data), .rd_en(rd_en),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_data(wr_data),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .rd_count(rd_count_a), .wr_count(wr_count_a), .err_conflict(err_conflict_a),
        .err_range(err_range_a), .err_proto(err_proto_a)
    );

    memref_port_responder dut_b (
        .clk(clk), .rst(rst), .addr_en(addr_en), .addr_data(addr_data), .rd_en(rd_en),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_data(wr_data),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .rd_count(rd_count_b), .wr_count(wr_count_b), .err_conflict(err_conflict_b),
        .err_range(err_range_b), .err_proto(err_proto_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Output monitor: pops the scoreboard on rd_valid and checks hold / timing.
    always @(negedge clk) begin
        if (rst) begin
            last_a = '0;
            last_b = '0;
            if (rd_valid_a || rd_valid_b) begin
                checks++; errors++;
                $display("FAIL valid_in_reset: got a=%0b b=%0b required 0", rd_valid_a, rd_valid_b);
            end
        end else begin
            if (rd_valid_a) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL rd_a_unexpected: got %h at cycle %0d, none pending", rd_data_a, ecnt);
                end else begin
                    ea = qa.pop_front();
                    if (rd_data_a !== ea.data || ecnt != ea.due) begin
                        errors++;
                        $display("FAIL rd_a: got %h @%0d required %h @%0d", rd_data_a, ecnt, ea.data, ea.due);
                    end
                end
                last_a = rd_data_a;
            end else begin
                checks++;
                if (rd_data_a !== last_a) begin
                    errors++;
                    $display("FAIL rd_a_hold: got %h required %h", rd_data_a, last_a);
                end
                if (qa.size() > 0 && qa[0].due <= ecnt) begin
                    errors++;
                    $display("FAIL rd_a_missing: no valid at %0d, required %h", ecnt, qa[0].data);
                    void'(qa.pop_front());
                end
            end
            if (rd_valid_b) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL rd_b_unexpected: got %h at cycle %0d, none pending", rd_data_b, ecnt);
                end else begin
                    eb = qb.pop_front();
                    if (rd_data_b !== eb.data || ecnt != eb.due) begin
                        errors++;
                        $display("FAIL rd_b: got %h @%0d required %h @%0d", rd_data_b, ecnt, eb.data, eb.due);
                    end
                end
                last_b = rd_data_b;
            end else begin
                checks++;
                if (rd_data_b !== last_b) begin
                    errors++;
                    $display("FAIL rd_b_hold: got %h required %h", rd_data_b, last_b);
                end
                if (qb.size() > 0 && qb[0].due <= ecnt) begin
                    errors++;
                    $display("FAIL rd_b_missing: no valid at %0d, required %h", ecnt, qb[0].data);
                    void'(qb.pop_front());
                end
            end
        end
    end

    function automatic logic [34:0] exp_status(input int i);
        return {rdc[i], wrc[i], econf[i], erng[i], eprot[i]};
    endfunction

    // Update model instance i for one sampled edge.
    task automatic model_edge(input int i, input logic r, input logic w, input logic [5:0] a,
                              input logic ae, input logic [31:0] wd, input logic ie,
                              input logic [5:0] ia, input logic [31:0] id);
        int   sz;
        int   lat;
        exp_t e;
        sz  = (i == 0) ? SZ_A : SZ_B;
        lat = (i == 0) ? LAT_A : LAT_B;
        if (r) begin
            e.data = (int'(a) < sz) ? mem_m[i][a] : 32'h0;
            e.due  = ecnt + lat - 1;
            if (i == 0) qa.push_back(e);
            else qb.push_back(e);
            if (rdc[i] != 16'hFFFF) rdc[i] = rdc[i] + 16'd1;
        end
        if (w && wrc[i] != 16'hFFFF) wrc[i] = wrc[i] + 16'd1;
        if ((r || ie) && w) econf[i] = 1'b1;
        if (((r || w) && int'(a) >= sz) || (ie && int'(ia) >= sz)) erng[i] = 1'b1;
        if (i == 0 && (r || w) && !ae) eprot[i] = 1'b1;
        if (w) begin
            if (int'(a) < sz) mem_m[i][a] = wd;
        end else if (ie && int'(ia) < sz) begin
            mem_m[i][ia] = id;
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic step(input logic r, input logic w, input logic [5:0] a, input logic ae,
                        input logic [31:0] wd, input logic ie, input logic [5:0] ia,
                        input logic [31:0] id);
        rd_en = r; wr_en = w; addr_data = a; addr_en = ae; wr_data = wd;
        init_en = ie; init_addr = ia; init_data = id;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_edge(i, r, w, a, ae, wd, ie, ia, id);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 6'd0, 0, 32'h0, 0, 6'd0, 32'h0);
    endtask

    task automatic rd(input logic [5:0] a);
        step(1, 0, a, 1, 32'h0, 0, 6'd0, 32'h0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        step(0, 1, a, 1, d, 0, 6'd0, 32'h0);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        step(0, 0, 6'd0, 0, 32'h0, 1, a, d);
    endtask

    task automatic assert_rst();
        rd_en = 0; wr_en = 0; init_en = 0; addr_en = 0;
        #2 rst = 1'b1;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            rdc[i] = '0; wrc[i] = '0; econf[i] = 0; erng[i] = 0; eprot[i] = 0;
        end
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        assert_rst();
        release_rst();
        checks++;
        if ({st_a, rd_valid_a, rd_data_a} !== {exp_status(0), 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_a: got %h required %h", {st_a, rd_valid_a, rd_data_a}, {exp_status(0), 33'h0});
        end
        checks++;
        if ({st_b, rd_valid_b, rd_data_b} !== {exp_status(1), 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_b: got %h required %h", {st_b, rd_valid_b, rd_data_b}, {exp_status(1), 33'h0});
        end
    endtask

    task automatic test_preload_read();
        preload(6'd5, 32'hA5A5_0001);
        idle(2);
        rd(6'd5);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || rd_count_a !== 16'd1) begin
            errors++;
            $display("FAIL preload_read_a: status %h required %h", st_a, exp_status(0));
        end
        checks++;
        if (st_b !== exp_status(1) || rd_count_b !== 16'd1) begin
            errors++;
            $display("FAIL preload_read_b: status %h required %h", st_b, exp_status(1));
        end
    endtask

    task automatic test_back_to_back();
        preload(6'd0, 32'd10);
        preload(6'd1, 32'd20);
        preload(6'd2, 32'd30);
        rd(6'd0);
        rd(6'd1);
        rd(6'd2);
        idle(5);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_drain: pending a=%0d b=%0d required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_write_conflict();
        wr(6'd7, 32'd99);
        rd(6'd7);
        idle(4);
        checks++;
        if (err_conflict_a !== 1'b0 || err_conflict_b !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pre: got a=%0b b=%0b required 0", err_conflict_a, err_conflict_b);
        end
        step(1, 1, 6'd7, 1, 32'd55, 0, 6'd0, 32'h0);
        rd(6'd7);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || err_conflict_a !== 1'b1) begin
            errors++;
            $display("FAIL conflict_a: status %h required %h", st_a, exp_status(0));
        end
        checks++;
        if (st_b !== exp_status(1) || err_conflict_b !== 1'b1) begin
            errors++;
            $display("FAIL conflict_b: status %h required %h", st_b, exp_status(1));
        end
    endtask

    task automatic test_init_conflict();
        assert_rst();
        release_rst();
        preload(6'd9, 32'h111);
        step(0, 1, 6'd8, 1, 32'h222, 1, 6'd9, 32'h333);
        rd(6'd9);
        rd(6'd8);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || st_b !== exp_status(1)) begin
            errors++;
            $display("FAIL init_conflict: a %h req %h, b %h req %h", st_a, exp_status(0), st_b, exp_status(1));
        end
    endtask

    task automatic test_range();
        assert_rst();
        release_rst();
        preload(6'd18, 32'h1818);
        wr(6'd50, 32'hDEAD);
        rd(6'd18);
        rd(6'd50);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || err_range_a !== 1'b1 || wr_count_a !== 16'd1) begin
            errors++;
            $display("FAIL range_a: status %h required %h", st_a, exp_status(0));
        end
        checks++;
        if (st_b !== exp_status(1) || err_range_b !== 1'b0) begin
            errors++;
            $display("FAIL range_b: status %h required %h", st_b, exp_status(1));
        end
        assert_rst();
        release_rst();
        preload(6'd60, 32'h6060);
        idle(1);
        checks++;
        if (st_a !== exp_status(0) || st_b !== exp_status(1)) begin
            errors++;
            $display("FAIL init_range: a %h req %h, b %h req %h", st_a, exp_status(0), st_b, exp_status(1));
        end
    endtask

    task automatic test_reset_flush();
        assert_rst();
        release_rst();
        preload(6'd3, 32'h3333);
        rd(6'd3);
        idle(1);
        assert_rst();
        #1;
        checks++;
        if ({st_a, rd_valid_a, rd_data_a} !== 68'h0 || {st_b, rd_valid_b, rd_data_b} !== 68'h0) begin
            errors++;
            $display("FAIL flush_outputs: a %h b %h required 0", {st_a, rd_valid_a, rd_data_a},
                     {st_b, rd_valid_b, rd_data_b});
        end
        release_rst();
        idle(4);
        rd(6'd3);
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0 || st_a !== exp_status(0)) begin
            errors++;
            $display("FAIL flush_after: pending a=%0d b=%0d status %h required %h", qa.size(),
                     qb.size(), st_a, exp_status(0));
        end
    endtask

    task automatic test_proto_saturate();
        assert_rst();
        release_rst();
        step(1, 0, 6'd3, 0, 32'h0, 0, 6'd0, 32'h0);
        step(0, 1, 6'd4, 0, 32'h4444, 0, 6'd0, 32'h0);
        rd(6'd4);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || err_proto_a !== 1'b1) begin
            errors++;
            $display("FAIL proto_a: status %h required %h", st_a, exp_status(0));
        end
        checks++;
        if (st_b !== exp_status(1) || err_proto_b !== 1'b0) begin
            errors++;
            $display("FAIL proto_b: status %h required %h", st_b, exp_status(1));
        end
        for (int k = 0; k < 65536; k++) rd(6'd3);
        idle(4);
        checks++;
        if (st_a !== exp_status(0) || rd_count_a !== 16'hFFFF || wr_count_a !== 16'd1) begin
            errors++;
            $display("FAIL saturate_a: status %h required %h", st_a, exp_status(0));
        end
        checks++;
        if (st_b !== exp_status(1) || rd_count_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate_b: status %h required %h", st_b, exp_status(1));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 64; j++) mem_m[i][j] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_preload_read();
        test_back_to_back();
        test_write_conflict();
        test_init_conflict();
        test_range();
        test_reset_flush();
        test_proto_saturate();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
